sccb_target: RTL and testbench
==============================

Name: sccb_target

Overview:
- SCCB/I2C target (responder) that decodes a master's SCL/SDA traffic: device-address match, register-address byte, write bytes, read bytes.
- Writes go out on a register write port; reads are fetched from an external register file.
- Used as an OV7670-style camera register model in simulation, and as an on-FPGA configuration target for the camera-config master.
- SCL is oversampled on clk, so clk must be at least 20x the SCL rate.

Parameters:
- DEV_ADDR, 7'h21, 7-bit target address (write byte 8'h42, read byte 8'h43).
- SYNC_STAGES, 2, synchroniser flops on scl_in and sda_in (minimum 2).

Ports:
- clk  input  1  system clock (100 MHz).
- reset_n  input  1  asynchronous, active-low reset.
- scl_in  input  1  SCL line sample.
- sda_in  input  1  SDA line sample.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- wr_en  output  1  one-clk write strobe.
- wr_addr  output  8  write register address.
- wr_data  output  8  write data.
- rd_addr  output  8  current register pointer for reads.
- rd_data  input  8  register contents at rd_addr; must be valid 1 clk after rd_addr changes.
- busy  output  1  high between a matched address and STOP.

Behaviour:
- Reset: all outputs are 0, pointer = 0, state = IDLE. Reset mid-transfer releases SDA immediately.
- Line handling:
  - scl_in and sda_in pass through SYNC_STAGES flops.
  - scl_rise and scl_fall are derived from the synchronised SCL.
  - START: synchronised SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Data timing: SDA is sampled on scl_rise, MSB first. The target changes sda_oe only on scl_fall.
- START or STOP in any state overrides the current state:
  - START goes to DEV_ADDR (repeated start is supported). The pointer is kept.
  - STOP goes to IDLE, clears busy and releases SDA.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits.
    - Bits [7:1] == DEV_ADDR: ACK_DEV, busy = 1.
    - Otherwise: WAIT_STOP with no ACK.
  - ACK_DEV: drive sda_oe = 1 from the scl_fall after bit 8 to the next scl_fall.
    - R/W = 0: go to REG_ADDR.
    - R/W = 1: go to RD_DATA.
  - REG_ADDR: shift 8 bits, load the pointer, then ACK_REG (ACK as above), then WR_DATA.
  - WR_DATA: shift 8 bits.
    - On the clk after the 8th scl_rise: wr_en = 1 for one cycle, wr_addr = pointer, wr_data = byte.
    - Then ACK_WR (ACK), pointer +1, back to WR_DATA.
  - RD_DATA:
    - At the scl_fall that ends the ACK, load the shift register from rd_data.
    - Drive sda_oe = ~bit on each scl_fall for 8 bits.
    - After the 8th bit, release SDA and go to RD_ACK; pointer +1.
  - RD_ACK: sample the master's bit on scl_rise.
    - 0 (ACK): RD_DATA.
    - 1 (NACK): WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- Pointer is 8 bits and wraps 0xFF to 0x00.
- rd_addr = pointer at all times.
- The SCCB "don't-care" 9th bit is tolerated: a NACK after a read is normal termination.
- STOP mid-byte discards the partial byte; no wr_en is issued.
- Simultaneous scl_fall and START/STOP detection: START/STOP wins.

Optional Feature:
- Macro SCCB_TARGET_GLITCH_FILTER_EN.
- Defined: each synchronised line passes a 3-sample majority filter before edge detection. This adds 2 clk of latency to all edges and suppresses pulses of 1 clk or shorter.
- Undefined: no filter; edges are taken directly from the synchroniser output.

Decomposition:
- Package sccb_pkg:
  - state enum sccb_tgt_state_t.
  - SCCB_ADDR_W = 8, SCCB_DATA_W = 8.
  - SCCB_OV7670_WR = 8'h42, SCCB_OV7670_RD = 8'h43.
- Sub-module sccb_line_sync: synchroniser, optional filter, and scl_rise/scl_fall/start_det/stop_det generation. One instance serves both lines.

Test Plan:
- Write 8'h42, reg 8'h12, data 8'h80, STOP -> ACK on all 3 bytes; one wr_en with wr_addr = 8'h12, wr_data = 8'h80; busy drops at STOP.
- Address 8'h40 followed by 2 bytes -> sda_oe stays 0 throughout; no wr_en; busy stays 0.
- Write 8'h42, reg 8'hFE, data 8'h11, 8'h22, 8'h33 -> wr_en at addresses FE, FF, 00; final pointer = 8'h01.
- Write 8'h42, reg 8'h0A, repeated START, 8'h43, model rd_data = 8'h76, master NACK -> SDA carries 0x76 MSB-first; no wr_en; target releases SDA.
- Read 8'h43 with master ACKing twice, then NACK -> 3 bytes read from pointer, pointer+1, pointer+2.
- reset_n low during the 5th bit of a data byte -> sda_oe = 0 and wr_en = 0 immediately. After release, a fresh write of 8'h42/8'h13/8'hE7 is accepted.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB/I2C target: state encoding, bus widths,
// OV7670 address bytes and the majority helper used by the optional line filter.
`timescale 1ns/1ps
package sccb_pkg;
   localparam int SCCB_ADDR_W = 8;
   localparam int SCCB_DATA_W = 8;

   localparam logic [7:0] SCCB_OV7670_WR = 8'h42;
   localparam logic [7:0] SCCB_OV7670_RD = 8'h43;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV_ADDR,
      ST_ACK_DEV,
      ST_REG_ADDR,
      ST_ACK_REG,
      ST_WR_DATA,
      ST_ACK_WR,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } sccb_tgt_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/sccb_target_if.sv
// Bus-side signals of the SCCB target: SCL/SDA lines plus register-file ports.
`timescale 1ns/1ps
interface sccb_target_if;
   import sccb_pkg::*;

   logic                   scl_in;
   logic                   sda_in;
   logic                   sda_oe;
   logic                   wr_en;
   logic [SCCB_ADDR_W-1:0] wr_addr;
   logic [SCCB_DATA_W-1:0] wr_data;
   logic [SCCB_ADDR_W-1:0] rd_addr;
   logic [SCCB_DATA_W-1:0] rd_data;
   logic                   busy;

   modport slave (
      input  scl_in, sda_in, rd_data,
      output sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
   );

   modport master (
      output scl_in, sda_in, rd_data,
      input  sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
   );
endinterface

// File: rtl/sccb_line_sync.sv
// Synchronises SCL/SDA and derives SCL edges plus START/STOP conditions.
// Define SCCB_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter per line.
`timescale 1ns/1ps
module sccb_line_sync
   import sccb_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_level,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);
   logic [SYNC_STAGES-1:0] scl_sync_reg;
   logic [SYNC_STAGES-1:0] sda_sync_reg;
   logic                   scl_line;
   logic                   sda_line;
   logic                   scl_prev_reg;
   logic                   sda_prev_reg;

   // Idle bus is high, so reset to 1 to avoid a phantom START after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync_reg <= '1;
         sda_sync_reg <= '1;
      end else begin
         scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
         sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
      end
   end

`ifdef SCCB_TARGET_GLITCH_FILTER_EN
   logic [1:0] scl_hist_reg;
   logic [1:0] sda_hist_reg;
   logic       scl_filt_reg;
   logic       sda_filt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_hist_reg <= '1;
         sda_hist_reg <= '1;
         scl_filt_reg <= 1'b1;
         sda_filt_reg <= 1'b1;
      end else begin
         scl_hist_reg <= {scl_hist_reg[0], scl_sync_reg[SYNC_STAGES-1]};
         sda_hist_reg <= {sda_hist_reg[0], sda_sync_reg[SYNC_STAGES-1]};
         scl_filt_reg <= majority3(scl_sync_reg[SYNC_STAGES-1], scl_hist_reg[0], scl_hist_reg[1]);
         sda_filt_reg <= majority3(sda_sync_reg[SYNC_STAGES-1], sda_hist_reg[0], sda_hist_reg[1]);
      end
   end

   assign scl_line = scl_filt_reg;
   assign sda_line = sda_filt_reg;
`else
   assign scl_line = scl_sync_reg[SYNC_STAGES-1];
   assign sda_line = sda_sync_reg[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_prev_reg <= 1'b1;
         sda_prev_reg <= 1'b1;
      end else begin
         scl_prev_reg <= scl_line;
         sda_prev_reg <= sda_line;
      end
   end

   assign sda_level = sda_line;
   assign scl_rise  = scl_line & ~scl_prev_reg;
   assign scl_fall  = ~scl_line & scl_prev_reg;
   assign start_det = scl_line & scl_prev_reg & sda_prev_reg & ~sda_line;
   assign stop_det  = scl_line & scl_prev_reg & ~sda_prev_reg & sda_line;
endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C register target: address match, register pointer, write strobes and reads.
// Optional SCCB_TARGET_GLITCH_FILTER_EN enables majority filtering in sccb_line_sync.
`timescale 1ns/1ps
module sccb_target
   import sccb_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h21,
   parameter int         SYNC_STAGES = 2
) (
   input logic          clk,
   input logic          reset_n,
   sccb_target_if.slave bus
);
   sccb_tgt_state_t  state_reg;
   logic [7:0]       shift_reg;
   logic [7:0]       ptr_reg;
   logic [7:0]       wr_addr_reg;
   logic [7:0]       wr_data_reg;
   logic [3:0]       bit_cnt_reg;
   logic             sda_oe_reg;
   logic             wr_en_reg;
   logic             busy_reg;
   logic             rw_reg;

   logic             sda_level;
   logic             scl_rise;
   logic             scl_fall;
   logic             start_det;
   logic             stop_det;
   logic [7:0]       shift_next;
   logic             byte_done;

   sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .scl_in    (bus.scl_in),
      .sda_in    (bus.sda_in),
      .sda_level (sda_level),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign shift_next = {shift_reg[6:0], sda_level};
   assign byte_done  = scl_rise && (bit_cnt_reg == 4'd7);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= ST_IDLE;
         shift_reg   <= '0;
         ptr_reg     <= '0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
         bit_cnt_reg <= '0;
         sda_oe_reg  <= 1'b0;
         wr_en_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         rw_reg      <= 1'b0;
      end else begin
         wr_en_reg <= 1'b0;
         // Bus conditions take priority over any coincident SCL edge.
         if (stop_det) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            sda_oe_reg  <= 1'b0;
            bit_cnt_reg <= '0;
         end else if (start_det) begin
            state_reg   <= ST_DEV_ADDR;
            sda_oe_reg  <= 1'b0;
            bit_cnt_reg <= '0;
         end else begin
            case (state_reg)
               ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                  if (scl_rise) begin
                     shift_reg   <= shift_next;
                     bit_cnt_reg <= byte_done ? 4'd0 : bit_cnt_reg + 4'd1;
                  end
                  if (byte_done) begin
                     if (state_reg == ST_DEV_ADDR) begin
                        if (shift_next[7:1] == DEV_ADDR) begin
                           state_reg <= ST_ACK_DEV;
                           busy_reg  <= 1'b1;
                           rw_reg    <= shift_next[0];
                        end else begin
                           state_reg <= ST_WAIT_STOP;
                        end
                     end else if (state_reg == ST_REG_ADDR) begin
                        ptr_reg   <= shift_next;
                        state_reg <= ST_ACK_REG;
                     end else begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= ptr_reg;
                        wr_data_reg <= shift_next;
                        ptr_reg     <= ptr_reg + 8'd1;
                        state_reg   <= ST_ACK_WR;
                     end
                  end
               end
               // First fall after the byte pulls SDA low, the next one ends the ACK.
               ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR: begin
                  if (scl_fall) begin
                     if (!sda_oe_reg) begin
                        sda_oe_reg <= 1'b1;
                     end else if (state_reg == ST_ACK_DEV && rw_reg) begin
                        sda_oe_reg  <= ~bus.rd_data[7];
                        shift_reg   <= {bus.rd_data[6:0], 1'b0};
                        bit_cnt_reg <= 4'd1;
                        state_reg   <= ST_RD_DATA;
                     end else begin
                        sda_oe_reg <= 1'b0;
                        state_reg  <= (state_reg == ST_ACK_DEV) ? ST_REG_ADDR : ST_WR_DATA;
                     end
                  end
               end
               ST_RD_DATA: begin
                  if (scl_fall) begin
                     if (bit_cnt_reg == 4'd0) begin
                        sda_oe_reg  <= ~bus.rd_data[7];
                        shift_reg   <= {bus.rd_data[6:0], 1'b0};
                        bit_cnt_reg <= 4'd1;
                     end else if (bit_cnt_reg < 4'd8) begin
                        sda_oe_reg  <= ~shift_reg[7];
                        shift_reg   <= {shift_reg[6:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     end else begin
                        sda_oe_reg  <= 1'b0;
                        ptr_reg     <= ptr_reg + 8'd1;
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_RD_ACK;
                     end
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     state_reg <= sda_level ? ST_WAIT_STOP : ST_RD_DATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.sda_oe  = sda_oe_reg;
   assign bus.wr_en   = wr_en_reg;
   assign bus.wr_addr = wr_addr_reg;
   assign bus.wr_data = wr_data_reg;
   assign bus.rd_addr = ptr_reg;
   assign bus.busy    = busy_reg;
endmodule

// File: tb/tb_sccb_target.sv
// Self-checking bench for sccb_target: table-driven write vectors, hand-written
// read/reset sequences and randomised transactions against a register-file model.
`timescale 1ns/1ps
module tb_sccb_target;
   import sccb_pkg::*;

   localparam int Q = 8;  // quarter SCL period in clk cycles

   typedef struct {
      logic [7:0]  dev;
      logic [7:0]  ra;
      int          n;
      logic [23:0] data;
      logic        exp_ack;
      logic [7:0]  exp_ptr;
   } wvec_t;

   logic clk = 1'b0;
   logic reset_n;
   logic m_drv;
   logic sda_line;
   int   checks = 0;
   int   errors = 0;

   logic [7:0]  regfile    [256];
   logic [7:0]  model_regs [256];
   logic [15:0] wr_q  [$];
   logic [15:0] exp_q [$];
   logic        oe_seen;
   logic [7:0]  model_ptr;
   wvec_t       vecs [4];

   always #5 clk = ~clk;

   sccb_target_if bus();

   sccb_target #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign sda_line   = !(m_drv || bus.sda_oe);
   assign bus.sda_in = sda_line;

   // External register file: written by the target, read one clk after rd_addr.
   always @(posedge clk) begin
      if (bus.wr_en) regfile[bus.wr_addr] = bus.wr_data;
   end
   always @(posedge clk) bus.rd_data <= regfile[bus.rd_addr];

   always @(negedge clk) begin
      if (bus.wr_en) wr_q.push_back({bus.wr_addr, bus.wr_data});
      if (bus.sda_oe) oe_seen = 1'b1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_drv = 1'b0;
      wait_clk(Q);
      bus.scl_in = 1'b1;
      wait_clk(2 * Q);
      m_drv = 1'b1;
      wait_clk(2 * Q);
      bus.scl_in = 1'b0;
      wait_clk(Q);
   endtask

   task automatic i2c_stop();
      m_drv = 1'b1;
      wait_clk(Q);
      bus.scl_in = 1'b1;
      wait_clk(2 * Q);
      m_drv = 1'b0;
      wait_clk(2 * Q);
   endtask

   task automatic write_bit(input logic b);
      m_drv = !b;
      wait_clk(Q);
      bus.scl_in = 1'b1;
      wait_clk(2 * Q);
      bus.scl_in = 1'b0;
      wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      m_drv = 1'b0;
      wait_clk(Q);
      bus.scl_in = 1'b1;
      wait_clk(Q);
      b = sda_line;
      wait_clk(Q);
      bus.scl_in = 1'b0;
      wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] v, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(b);
      ack = !b;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] v);
      logic b;
      v = '0;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         v[i] = b;
      end
      write_bit(!ack);
   endtask

   // Compare captured write strobes against the expected list, in order.
   task automatic cmp_writes(input string tag);
      chk({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
         chk({tag, "_wr_addr_data"}, 32'(wr_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      logic       a;
      logic       b;
      logic [7:0] rb;
      logic [7:0] ra;
      logic [7:0] d;
      int         op;
      int         n;

      for (int i = 0; i < 256; i++) begin
         regfile[i]    = 8'(i * 37 + 11);
         model_regs[i] = 8'(i * 37 + 11);
      end
      regfile[8'h0A] = 8'h76;  model_regs[8'h0A] = 8'h76;
      regfile[8'h30] = 8'hA5;  model_regs[8'h30] = 8'hA5;

      vecs[0] = '{dev: SCCB_OV7670_WR, ra: 8'h12, n: 1, data: 24'h000080, exp_ack: 1'b1, exp_ptr: 8'h13};
      vecs[1] = '{dev: 8'h40,          ra: 8'h55, n: 1, data: 24'h0000AA, exp_ack: 1'b0, exp_ptr: 8'h13};
      vecs[2] = '{dev: SCCB_OV7670_WR, ra: 8'hFE, n: 3, data: 24'h332211, exp_ack: 1'b1, exp_ptr: 8'h01};
      vecs[3] = '{dev: 8'hC2,          ra: 8'h01, n: 1, data: 24'h00005A, exp_ack: 1'b0, exp_ptr: 8'h01};

      reset_n    = 1'b0;
      bus.scl_in = 1'b1;
      m_drv      = 1'b0;
      oe_seen    = 1'b0;
      wait_clk(5);
      chk("reset_sda_oe", 32'(bus.sda_oe), 32'd0);
      chk("reset_wr_en", 32'(bus.wr_en), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
      reset_n = 1'b1;
      wait_clk(5);

      // Table-driven write transactions.
      for (int v = 0; v < 4; v++) begin
         wr_q.delete();
         exp_q.delete();
         oe_seen = 1'b0;
         i2c_start();
         write_byte(vecs[v].dev, a);
         chk($sformatf("v%0d_dev_ack", v), 32'(a), 32'(vecs[v].exp_ack));
         chk($sformatf("v%0d_busy_mid", v), 32'(bus.busy), 32'(vecs[v].exp_ack));
         write_byte(vecs[v].ra, a);
         chk($sformatf("v%0d_reg_ack", v), 32'(a), 32'(vecs[v].exp_ack));
         for (int i = 0; i < vecs[v].n; i++) begin
            d = vecs[v].data[8*i +: 8];
            write_byte(d, a);
            chk($sformatf("v%0d_data%0d_ack", v, i), 32'(a), 32'(vecs[v].exp_ack));
            if (vecs[v].exp_ack) exp_q.push_back({8'(vecs[v].ra + 8'(i)), d});
         end
         i2c_stop();
         wait_clk(4);
         chk($sformatf("v%0d_busy_stop", v), 32'(bus.busy), 32'd0);
         cmp_writes($sformatf("v%0d", v));
         chk($sformatf("v%0d_ptr", v), 32'(bus.rd_addr), 32'(vecs[v].exp_ptr));
         if (!vecs[v].exp_ack) chk($sformatf("v%0d_oe_seen", v), 32'(oe_seen), 32'd0);
      end
      for (int i = 0; i < 3; i++) model_regs[8'(8'hFE + 8'(i))] = vecs[2].data[8*i +: 8];
      model_regs[8'h12] = 8'h80;

      // Register write then repeated START into a single NACKed read.
      wr_q.delete();
      exp_q.delete();
      i2c_start();
      write_byte(SCCB_OV7670_WR, a);
      write_byte(8'h0A, a);
      i2c_start();
      write_byte(SCCB_OV7670_RD, a);
      chk("rs_rd_dev_ack", 32'(a), 32'd1);
      read_byte(1'b0, rb);
      chk("rs_rd_byte", 32'(rb), 32'h76);
      chk("rs_sda_released", 32'(bus.sda_oe), 32'd0);
      i2c_stop();
      wait_clk(4);
      cmp_writes("rs");
      model_ptr = 8'h0B;
      chk("rs_ptr", 32'(bus.rd_addr), 32'(model_ptr));

      // Three-byte read continuing from the current pointer.
      i2c_start();
      write_byte(SCCB_OV7670_RD, a);
      for (int i = 0; i < 3; i++) begin
         read_byte(i < 2, rb);
         chk($sformatf("rd3_byte%0d", i), 32'(rb), 32'(model_regs[model_ptr]));
         model_ptr = model_ptr + 8'd1;
      end
      i2c_stop();
      wait_clk(4);
      chk("rd3_ptr", 32'(bus.rd_addr), 32'(model_ptr));

      // Reset asserted while the target drives the 5th bit of a read byte (0xA5 -> bit3 = 0).
      wr_q.delete();
      i2c_start();
      write_byte(SCCB_OV7670_WR, a);
      write_byte(8'h30, a);
      i2c_start();
      write_byte(SCCB_OV7670_RD, a);
      for (int i = 0; i < 4; i++) read_bit(b);
      m_drv = 1'b0;
      wait_clk(Q);
      bus.scl_in = 1'b1;
      wait_clk(Q);
      chk("rst_pre_oe", 32'(bus.sda_oe), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      wait_clk(3);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      reset_n = 1'b1;
      wait_clk(4);
      exp_q.delete();
      i2c_start();
      write_byte(SCCB_OV7670_WR, a);
      chk("post_rst_dev_ack", 32'(a), 32'd1);
      write_byte(8'h13, a);
      chk("post_rst_reg_ack", 32'(a), 32'd1);
      write_byte(8'hE7, a);
      chk("post_rst_data_ack", 32'(a), 32'd1);
      i2c_stop();
      wait_clk(4);
      exp_q.push_back(16'h13E7);
      cmp_writes("post_rst");
      model_regs[8'h13] = 8'hE7;
      model_ptr = 8'h14;
      chk("post_rst_ptr", 32'(bus.rd_addr), 32'(model_ptr));

      // Randomised writes, reads and write-then-read transactions.
      for (int t = 0; t < 14; t++) begin
         op = $urandom_range(0, 2);
         n  = $urandom_range(1, 3);
         ra = 8'($urandom);
         wr_q.delete();
         exp_q.delete();
         i2c_start();
         if (op == 1) begin
            write_byte(SCCB_OV7670_RD, a);
            chk($sformatf("rnd%0d_rd_ack", t), 32'(a), 32'd1);
         end else begin
            write_byte(SCCB_OV7670_WR, a);
            chk($sformatf("rnd%0d_wr_ack", t), 32'(a), 32'd1);
            write_byte(ra, a);
            chk($sformatf("rnd%0d_reg_ack", t), 32'(a), 32'd1);
            model_ptr = ra;
         end
         if (op == 0) begin
            for (int i = 0; i < n; i++) begin
               d = 8'($urandom);
               write_byte(d, a);
               chk($sformatf("rnd%0d_data_ack", t), 32'(a), 32'd1);
               exp_q.push_back({model_ptr, d});
               model_regs[model_ptr] = d;
               model_ptr = model_ptr + 8'd1;
            end
         end else begin
            if (op == 2) begin
               i2c_start();
               write_byte(SCCB_OV7670_RD, a);
               chk($sformatf("rnd%0d_rs_ack", t), 32'(a), 32'd1);
            end
            for (int i = 0; i < n; i++) begin
               read_byte(i < n - 1, rb);
               chk($sformatf("rnd%0d_rd_byte", t), 32'(rb), 32'(model_regs[model_ptr]));
               model_ptr = model_ptr + 8'd1;
            end
         end
         i2c_stop();
         wait_clk(4);
         cmp_writes($sformatf("rnd%0d", t));
         chk($sformatf("rnd%0d_ptr", t), 32'(bus.rd_addr), 32'(model_ptr));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
